// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command sequencer for a small register file: parses write/read frames,
// strobes the register file and returns read data to the transmitter.
module reg_file_cmd_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD        = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD        = 8'hBB,
    parameter int                    RD_TIMEOUT    = 8,
    parameter int                    FRAME_TIMEOUT = 1024,
    parameter int                    CNT_WIDTH     = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] R_REG_DATA,
    input  logic                  R_DATA_VALID,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] REG_ADDRESS,
    output logic [DATA_WIDTH-1:0] W_REG_DATA,
    output logic                  W_REG_EN,
    output logic                  R_REG_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CTRL_BUSY,
    output logic                  CMD_ERR,
    output logic                  RD_TO_ERR,
    output logic                  RX_OVERRUN
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST    = CNT_WIDTH'(RD_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, txdata_q;
    logic                  wen_q, ren_q, txvld_q, busy_q, cmderr_q, rdto_q, ovr_q;

    logic in_frame, is_opcode, frame_to, rd_to, no_accept;

    assign in_frame  = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);
    assign is_opcode = (RX_P_DATA == WR_CMD) || (RX_P_DATA == RD_CMD);
    assign frame_to  = (cnt_q == FRAME_LAST);
    assign rd_to     = (cnt_q == RD_LAST);
    // Bytes arriving while a transaction is executing are dropped, never parsed.
    assign no_accept = (state_q == WR_EXEC) || (state_q == RD_EXEC) ||
                       (state_q == RD_WAIT) || (state_q == TX_SEND);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD && RX_P_DATA == WR_CMD)      state_d = WR_ADDR;
                else if (RX_D_VLD && RX_P_DATA == RD_CMD) state_d = RD_ADDR;
            end
            WR_ADDR: if (RX_D_VLD) state_d = WR_DATA; else if (frame_to) state_d = IDLE;
            WR_DATA: if (RX_D_VLD) state_d = WR_EXEC; else if (frame_to) state_d = IDLE;
            WR_EXEC: state_d = IDLE;
            RD_ADDR: if (RX_D_VLD) state_d = RD_EXEC; else if (frame_to) state_d = IDLE;
            RD_EXEC: state_d = RD_WAIT;
            RD_WAIT: if (R_DATA_VALID) state_d = TX_SEND; else if (rd_to) state_d = IDLE;
            TX_SEND: if (!TX_BUSY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            txdata_q <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            txvld_q  <= 1'b0;
            busy_q   <= 1'b0;
            cmderr_q <= 1'b0;
            rdto_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Timeout counter restarts on every state change, i.e. every accepted byte.
            if (state_d != state_q || state_d == IDLE) cnt_q <= '0;
            else                                       cnt_q <= cnt_q + 1'b1;

            if ((state_q == WR_ADDR || state_q == RD_ADDR) && RX_D_VLD)
                addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (state_q == WR_DATA && RX_D_VLD)
                wdata_q <= RX_P_DATA;
            if (state_q == RD_WAIT && R_DATA_VALID)
                txdata_q <= R_REG_DATA;

            wen_q    <= (state_q == WR_EXEC);
            ren_q    <= (state_q == RD_EXEC);
            txvld_q  <= (state_d == TX_SEND);
            busy_q   <= (state_d != IDLE);
            cmderr_q <= (state_q == IDLE && RX_D_VLD && !is_opcode) ||
                        (in_frame && !RX_D_VLD && frame_to);
            rdto_q   <= (state_q == RD_WAIT) && !R_DATA_VALID && rd_to;
            ovr_q    <= RX_D_VLD && no_accept;
        end
    end

    assign REG_ADDRESS = addr_q;
    assign W_REG_DATA  = wdata_q;
    assign W_REG_EN    = wen_q;
    assign R_REG_EN    = ren_q;
    assign TX_P_DATA   = txdata_q;
    assign TX_D_VLD    = txvld_q;
    assign CTRL_BUSY   = busy_q;
    assign CMD_ERR     = cmderr_q;
    assign RD_TO_ERR   = rdto_q;
    assign RX_OVERRUN  = ovr_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl: per-cycle vector table plus hand-written
// sequences for TX backpressure and the frame timeout.
module tb_reg_file_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA, R_REG_DATA, W_REG_DATA, TX_P_DATA;
    logic       RX_D_VLD, R_DATA_VALID, TX_BUSY;
    logic [3:0] REG_ADDRESS;
    logic       W_REG_EN, R_REG_EN, TX_D_VLD, CTRL_BUSY, CMD_ERR, RD_TO_ERR, RX_OVERRUN;

    reg_file_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .R_REG_DATA(R_REG_DATA), .R_DATA_VALID(R_DATA_VALID), .TX_BUSY(TX_BUSY),
        .REG_ADDRESS(REG_ADDRESS), .W_REG_DATA(W_REG_DATA),
        .W_REG_EN(W_REG_EN), .R_REG_EN(R_REG_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY),
        .CMD_ERR(CMD_ERR), .RD_TO_ERR(RD_TO_ERR), .RX_OVERRUN(RX_OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rst, vld;
        logic [7:0] rx;
        logic       rdv;
        logic [7:0] rd;
        logic       busy;
    } in_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] wd;
        logic       wen, ren;
        logic [7:0] td;
        logic       tv, bz, ce, rt, ov;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic in_t I(logic rst, logic vld, logic [7:0] rx, logic rdv, logic [7:0] rd,
                              logic busy);
        I = '{rst, vld, rx, rdv, rd, busy};
    endfunction

    function automatic out_t O(logic [3:0] a, logic [7:0] wd, logic we, logic re, logic [7:0] td,
                               logic tv, logic bz, logic ce, logic rt, logic ov);
        O = '{a, wd, we, re, td, tv, bz, ce, rt, ov};
    endfunction

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    function automatic out_t cur();
        cur = {REG_ADDRESS, W_REG_DATA, W_REG_EN, R_REG_EN, TX_P_DATA,
               TX_D_VLD, CTRL_BUSY, CMD_ERR, RD_TO_ERR, RX_OVERRUN};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic vld, input logic [7:0] d);
        RX_D_VLD = vld; RX_P_DATA = d;
        @(posedge CLK); #1;
    endtask

    localparam in_t IDL = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    initial begin
        RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = '0;
        R_DATA_VALID = 1'b0; R_REG_DATA = '0; TX_BUSY = 1'b0;

        // reset and idle
        add("rst0",   I(1,0,8'h00,0,8'h00,0), O(0,8'h00,0,0,8'h00,0,0,0,0,0));
        add("rst1",   I(1,0,8'h00,0,8'h00,0), O(0,8'h00,0,0,8'h00,0,0,0,0,0));
        add("idle",   IDL,                    O(0,8'h00,0,0,8'h00,0,0,0,0,0));
        // write AA,05,3C
        add("w_cmd",  I(0,1,8'hAA,0,8'h00,0), O(0,8'h00,0,0,8'h00,0,1,0,0,0));
        add("w_adr",  I(0,1,8'h05,0,8'h00,0), O(5,8'h00,0,0,8'h00,0,1,0,0,0));
        add("w_dat",  I(0,1,8'h3C,0,8'h00,0), O(5,8'h3C,0,0,8'h00,0,1,0,0,0));
        add("w_exe",  IDL,                    O(5,8'h3C,1,0,8'h00,0,0,0,0,0));
        add("w_end",  IDL,                    O(5,8'h3C,0,0,8'h00,0,0,0,0,0));
        // read BB,02, data 81 one cycle after R_REG_EN
        add("r_cmd",  I(0,1,8'hBB,0,8'h00,0), O(5,8'h3C,0,0,8'h00,0,1,0,0,0));
        add("r_adr",  I(0,1,8'h02,0,8'h00,0), O(2,8'h3C,0,0,8'h00,0,1,0,0,0));
        add("r_exe",  IDL,                    O(2,8'h3C,0,1,8'h00,0,1,0,0,0));
        add("r_wt",   IDL,                    O(2,8'h3C,0,0,8'h00,0,1,0,0,0));
        add("r_dv",   I(0,0,8'h00,1,8'h81,0), O(2,8'h3C,0,0,8'h81,1,1,0,0,0));
        add("r_tx",   IDL,                    O(2,8'h3C,0,0,8'h81,0,0,0,0,0));
        // unknown opcode
        add("e_op",   I(0,1,8'h7E,0,8'h00,0), O(2,8'h3C,0,0,8'h81,0,0,1,0,0));
        add("e_end",  IDL,                    O(2,8'h3C,0,0,8'h81,0,0,0,0,0));
        // read addr 0x13 (-> 3), overrun byte in RD_WAIT, then read timeout
        add("t_cmd",  I(0,1,8'hBB,0,8'h00,0), O(2,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("t_adr",  I(0,1,8'h13,0,8'h00,0), O(3,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("t_exe",  IDL,                    O(3,8'h3C,0,1,8'h81,0,1,0,0,0));
        add("t_w0",   IDL,                    O(3,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("t_ovr",  I(0,1,8'hAA,0,8'h00,0), O(3,8'h3C,0,0,8'h81,0,1,0,0,1));
        for (int k = 2; k <= 6; k++)
            add($sformatf("t_w%0d", k), IDL,  O(3,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("t_rto",  IDL,                    O(3,8'h3C,0,0,8'h81,0,0,0,1,0));
        add("t_end",  IDL,                    O(3,8'h3C,0,0,8'h81,0,0,0,0,0));
        // reset mid-write, then a clean write AA,01,FF
        add("m_cmd",  I(0,1,8'hAA,0,8'h00,0), O(3,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("m_adr",  I(0,1,8'h05,0,8'h00,0), O(5,8'h3C,0,0,8'h81,0,1,0,0,0));
        add("m_rst",  I(1,0,8'h00,0,8'h00,0), O(0,8'h00,0,0,8'h00,0,0,0,0,0));
        add("m_rel",  IDL,                    O(0,8'h00,0,0,8'h00,0,0,0,0,0));
        add("m_cmd2", I(0,1,8'hAA,0,8'h00,0), O(0,8'h00,0,0,8'h00,0,1,0,0,0));
        add("m_adr2", I(0,1,8'h01,0,8'h00,0), O(1,8'h00,0,0,8'h00,0,1,0,0,0));
        add("m_dat2", I(0,1,8'hFF,0,8'h00,0), O(1,8'hFF,0,0,8'h00,0,1,0,0,0));
        add("m_exe2", IDL,                    O(1,8'hFF,1,0,8'h00,0,0,0,0,0));
        add("m_end2", IDL,                    O(1,8'hFF,0,0,8'h00,0,0,0,0,0));

        for (int v = 0; v < tbl.size(); v++) begin
            RST          = tbl[v].i.rst;
            RX_D_VLD     = tbl[v].i.vld;
            RX_P_DATA    = tbl[v].i.rx;
            R_DATA_VALID = tbl[v].i.rdv;
            R_REG_DATA   = tbl[v].i.rd;
            TX_BUSY      = tbl[v].i.busy;
            @(posedge CLK); #1;
            chk(tbl[v].name, 32'(cur()), 32'(tbl[v].o));
        end

        // TX backpressure: read addr 3 returning 20, TX_BUSY high for 10 valid cycles
        begin
            int  n = 0;
            bit  bad = 1'b0;
            bit  ren = 1'b0;
            TX_BUSY = 1'b1;
            tick(1'b1, 8'hBB);
            tick(1'b1, 8'h03);
            for (int k = 0; k < 5 && !ren; k++) begin
                tick(1'b0, 8'h00);
                ren = R_REG_EN;
            end
            chk("bp_ren", 32'(ren), 32'd1);
            chk("bp_addr", 32'(REG_ADDRESS), 32'h3);
            R_DATA_VALID = 1'b1; R_REG_DATA = 8'h20;
            tick(1'b0, 8'h00);
            R_DATA_VALID = 1'b0; R_REG_DATA = 8'h00;
            for (int k = 0; k < 40; k++) begin
                if (TX_D_VLD) begin
                    n++;
                    if (TX_P_DATA !== 8'h20) bad = 1'b1;
                    if (n == 11) TX_BUSY = 1'b0;
                end else if (n > 0) begin
                    break;
                end
                tick(1'b0, 8'h00);
            end
            chk("bp_vld_cycles", 32'(n), 32'd11);
            chk("bp_data_stable", 32'(bad), 32'd0);
            chk("bp_idle", 32'(CTRL_BUSY), 32'd0);
            TX_BUSY = 1'b0;
        end

        // frame timeout: AA then silence
        begin
            int n = 0;
            bit got = 1'b0;
            bit wen = 1'b0;
            tick(1'b1, 8'hAA);
            chk("ft_busy", 32'(CTRL_BUSY), 32'd1);
            while (n < 1100 && !got) begin
                tick(1'b0, 8'h00);
                n++;
                if (W_REG_EN) wen = 1'b1;
                got = CMD_ERR;
            end
            chk("ft_err_seen", 32'(got), 32'd1);
            chk("ft_err_cycle", 32'(n), 32'd1024);
            chk("ft_idle", 32'(CTRL_BUSY), 32'd0);
            chk("ft_no_write", 32'(wen), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
